// File: rtl/alu_tx_pkg.sv
// Shared definitions for the ALU result transmitter: FSM encoding, line levels,
// status byte layout and frame count.
package alu_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic        StartBit     = 1'b0;
  localparam logic        StopBit      = 1'b1;
  localparam logic        IdleLevel    = 1'b1;
  localparam int unsigned StatusOvfBit = 0;
  localparam int unsigned NumFrames    = 2;

endpackage

// File: rtl/alu_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last
// cycle of each bit. restart_i holds the count at zero.
module alu_tx_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned     CntW   = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    tick_o = !restart_i && (cnt_q == CntMax);
    cnt_d  = (restart_i || tick_o) ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_result_tx.sv
// Serial transmitter for a latched ALU result: result frame then status frame, 8N1.
// Define ALU_RESULT_TX_PARITY_EN to add an even-parity bit to each frame.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int unsigned NB_DATA      = 8,
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_result,
  input  logic               i_overflow,
  input  logic               i_send,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned       BitW      = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [BitW-1:0]   LastBit   = BitW'(NB_DATA - 1);
  localparam int unsigned       FrameW    = $clog2(NumFrames);
  localparam logic [FrameW-1:0] LastFrame = FrameW'(NumFrames - 1);

  tx_state_e          state_d, state_q;
  logic [BitW-1:0]    bit_d, bit_q;
  logic [FrameW-1:0]  frame_d, frame_q;
  logic [NB_DATA-1:0] result_d, result_q, payload_d;
  logic               ovf_d, ovf_q;
  logic               tx_d, tx_q;
  logic               done_d, done_q;
  logic               baud_restart, bit_tick;

  function automatic logic [NB_DATA-1:0] status_byte(input logic ovf);
    logic [NB_DATA-1:0] s;
    s               = '0;
    s[StatusOvfBit] = ovf;
    return s;
  endfunction

  assign baud_restart = (state_q == StIdle);

  alu_tx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (i_clk),
    .rst_ni   (i_reset),
    .restart_i(baud_restart),
    .tick_o   (bit_tick)
  );

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_send) begin
          state_d  = StStart;
          bit_d    = '0;
          frame_d  = '0;
          result_d = i_result;
          ovf_d    = i_overflow;
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_q == LastBit) begin
`ifdef ALU_RESULT_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      StParity: begin
        if (bit_tick) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_tick) begin
          if (frame_q == LastFrame) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StStart;
            frame_d = frame_q + FrameW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is registered from next-state values so o_tx is glitch-free.
    payload_d = (frame_d == '0) ? result_d : status_byte(ovf_d);
    case (state_d)
      StStart:  tx_d = StartBit;
      StData:   tx_d = payload_d[bit_d];
`ifdef ALU_RESULT_TX_PARITY_EN
      StParity: tx_d = ^payload_d;
`endif
      StStop:   tx_d = StopBit;
      default:  tx_d = IdleLevel;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= StIdle;
      bit_q    <= '0;
      frame_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      tx_q     <= IdleLevel;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != StIdle);
  assign o_done = done_q;

endmodule
